// File: rtl/matrix_pkg.sv
// Shared lane geometry and collector FSM encoding for the matrix MAC datapath.
// The MAC stage and the result collector both size their words from these constants.
package matrix_pkg;

    localparam int LANE_W = 16;
    localparam int LANES  = 4;
    localparam int WORD_W = LANE_W * LANES;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } mrc_state_t;

    // Per-lane modular add; carries never cross a lane boundary.
    function automatic logic [WORD_W-1:0] lane_add(input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
        logic [WORD_W-1:0] sum;
        sum = {WORD_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sum[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W] + b[i*LANE_W +: LANE_W];
        end
        return sum;
    endfunction

endpackage

// File: rtl/mrc_fifo.sv
// Synchronous FIFO whose head word sits in a register; a pop and a push on the
// same edge are resolved pop-first, so a full FIFO can still accept while draining.
module mrc_fifo import matrix_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int W     = WORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_next_s;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_pop_s;
    logic [LW-1:0] level_next_s;
    logic [W-1:0]  head_r;
    logic [W-1:0]  head_next_s;
    logic          empty_r;
    logic          full_r;
    logic          pop_s;
    logic          push_s;

    // Resolve the pop first, then decide whether the push fits and what the new head is.
    always_comb begin
        pop_s        = pop && !empty_r;
        push_s       = push && (!full_r || pop_s);
        rd_next_s    = rd_ptr_r + AW'(pop_s);
        level_pop_s  = level_r - LW'(pop_s);
        level_next_s = level_pop_s + LW'(push_s);
        if (level_pop_s == {LW{1'b0}}) begin
            head_next_s = push_s ? wr_data : {W{1'b0}};
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage array; the slot being written is never the one read as the new head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy flags and the registered head word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            head_r   <= {W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(push_s);
            rd_ptr_r <= rd_next_s;
            level_r  <= level_next_s;
            empty_r  <= (level_next_s == {LW{1'b0}});
            full_r   <= (level_next_s == LW'(DEPTH));
            head_r   <= head_next_s;
        end
    end

    assign head_data = head_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign level     = level_r;

endmodule

// File: rtl/matrix_result_collector.sv
// Biases packed MAC results, buffers them and drains them tagged with row/last,
// bounding one ROWS x COLS tile with an IDLE/COLLECT/DRAIN frame FSM.
module matrix_result_collector import matrix_pkg::*; #(
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] macab_in,
    input  logic              macab_in_val,
    input  logic [WORD_W-1:0] bias_in,
    output logic [WORD_W-1:0] res_data,
    output logic              res_val,
    input  logic              res_ready,
    output logic              res_last,
    output logic [15:0]       res_row,
    output logic              done,
    output logic              busy,
    output logic [1:0]        err
);

    localparam int TOTAL = ROWS * COLS;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    mrc_state_t        state_r;
    mrc_state_t        state_next_s;
    logic [31:0]       in_cnt_r;
    logic              stage_val_r;
    logic [WORD_W-1:0] stage_data_r;
    logic [15:0]       col_r;
    logic [15:0]       row_r;
    logic [15:0]       col_next_s;
    logic [15:0]       row_next_s;
    logic              last_r;
    logic [1:0]        err_r;
    logic [1:0]        err_next_s;
    logic              done_r;
    logic              busy_r;
    logic              accept_s;
    logic              clear_s;
    logic              unexp_s;
    logic              overflow_s;
    logic              done_next_s;
    logic              busy_next_s;
    logic              last_in_s;
    logic              drain_done_s;
    logic              pop_fire_s;
    logic [WORD_W-1:0] fifo_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [LVL_W-1:0]  fifo_level_s;

    mrc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (stage_val_r),
        .wr_data   (stage_data_r),
        .pop       (res_ready),
        .head_data (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level_s)
    );

    assign pop_fire_s   = !fifo_empty_s && res_ready;
    assign last_in_s    = (in_cnt_r == 32'(TOTAL - 1));
    assign drain_done_s = !stage_val_r && (fifo_level_s == {LVL_W{1'b0}});
    // A dropped word still counts toward the tile, so the frame always terminates.
    assign overflow_s   = stage_val_r && fifo_full_s && !pop_fire_s;

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_COLLECT;
                else       state_next_s = ST_IDLE;
            end
            ST_COLLECT: begin
                if (macab_in_val && last_in_s) state_next_s = ST_DRAIN;
                else                           state_next_s = ST_COLLECT;
            end
            ST_DRAIN: begin
                if (drain_done_s) state_next_s = ST_IDLE;
                else              state_next_s = ST_DRAIN;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Frame output decode: input acceptance, tile clear, protocol errors, done/busy.
    always_comb begin
        accept_s = 1'b0;
        clear_s  = 1'b0;
        unexp_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clear_s = start;
                unexp_s = macab_in_val;
            end
            ST_COLLECT: begin
                accept_s = macab_in_val;
            end
            ST_DRAIN: begin
                unexp_s = macab_in_val;
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
        err_next_s  = (clear_s ? 2'b00 : err_r) | {unexp_s, overflow_s};
        done_next_s = (state_r == ST_DRAIN) && drain_done_s;
        busy_next_s = (state_next_s != ST_IDLE) || done_next_s;
    end

    // Output column/row tracking, advanced only when the consumer takes a word.
    always_comb begin
        col_next_s = col_r;
        row_next_s = row_r;
        if (clear_s) begin
            col_next_s = 16'd0;
            row_next_s = 16'd0;
        end else if (pop_fire_s) begin
            if (col_r == 16'(COLS - 1)) begin
                col_next_s = 16'd0;
                row_next_s = row_r + 16'd1;
            end else begin
                col_next_s = col_r + 16'd1;
                row_next_s = row_r;
            end
        end else begin
            col_next_s = col_r;
            row_next_s = row_r;
        end
    end

    // Input stage register holding the biased word, plus the accepted-word count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_val_r  <= 1'b0;
            stage_data_r <= {WORD_W{1'b0}};
            in_cnt_r     <= 32'd0;
        end else begin
            stage_val_r <= accept_s;
            if (accept_s) begin
                stage_data_r <= lane_add(macab_in, bias_in);
            end
            if (clear_s) begin
                in_cnt_r <= 32'd0;
            end else if (accept_s) begin
                in_cnt_r <= in_cnt_r + 32'd1;
            end
        end
    end

    // Registered tags and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r  <= 16'd0;
            row_r  <= 16'd0;
            last_r <= 1'b0;
            err_r  <= 2'b00;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            col_r  <= col_next_s;
            row_r  <= row_next_s;
            last_r <= (col_next_s == 16'(COLS - 1));
            err_r  <= err_next_s;
            done_r <= done_next_s;
            busy_r <= busy_next_s;
        end
    end

    assign res_data = fifo_head_s;
    assign res_val  = !fifo_empty_s;
    assign res_last = last_r;
    assign res_row  = row_r;
    assign done     = done_r;
    assign busy     = busy_r;
    assign err      = err_r;

endmodule
